wb_master_arbiter: RTL

WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

---
 rtl/wb_master_arbiter_pkg.sv | 41 ++++
 rtl/wb_master_arbiter_timeout.sv | 35 +++
 rtl/wb_master_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/wb_master_arbiter_pkg.sv
// Shared wishbone definitions for the two-master arbiter.
// Holds the bus widths, the owner-state encoding, the request payload struct
// and the owner-to-grant helper used by wb_master_arbiter and wb_timeout.
package wb_master_arbiter_pkg;

   localparam int unsigned ADR_W = 24;
   localparam int unsigned DAT_W = 8;
   localparam int unsigned SEL_W = 1;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned GNT_W = 2;

   // Encoding matches the one-hot grant value (m0 -> 2'b01, m1 -> 2'b10).
   typedef enum logic [1:0] {
      OWN_IDLE = 2'd0,
      OWN_M0   = 2'd1,
      OWN_M1   = 2'd2
   } owner_e;

   // One master's request toward the shared slave bus.
   typedef struct packed {
      logic             cyc;
      logic             stb;
      logic             we;
      logic [0:SEL_W-1] sel;
      logic [0:ADR_W-1] adr;
      logic [0:DAT_W-1] dat;
   } wb_req_t;

   // Grant vector for an owner state; 2'b00 when idle.
   function automatic logic [0:GNT_W-1] owner_grant(input owner_e owner);
      logic [0:GNT_W-1] g;
      g = '0;
      case (owner)
         OWN_M0:  g = 2'b01;
         OWN_M1:  g = 2'b10;
         default: g = 2'b00;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/wb_master_arbiter_timeout.sv
// wb_timeout: wait counter for an outstanding strobe.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   stb         - strobe currently presented to the slave (before abort masking)
//   ack         - slave acknowledge
//   timeout_c   - combinational: this cycle is the last allowed wait cycle
module wb_timeout
   import wb_master_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic stb,
   input  logic ack,
   output logic timeout_c
);

   logic [CNT_W-1:0] cnt_q;

   // Ack in the same cycle wins over the timeout.
   assign timeout_c = stb && !ack && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // Count unacknowledged strobe cycles; any ack, idle strobe or abort restarts.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (stb && !ack && !timeout_c) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end else begin
         cnt_q <= '0;
      end
   end

endmodule

// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter: two-master wishbone arbiter with round-robin ownership
// and strobe timeout.
// Ports:
//   clk, reset                 - system clock, synchronous active-high reset
//   m0_* / m1_*                - master ports (m0 = overlay/debug CPU, m1 = loader DMA)
//   s_*                        - shared slave bus toward the mainboard port
//   grant_o                    - current owner: 2'b01 = m0, 2'b10 = m1, 2'b00 idle
module wb_master_arbiter
   import wb_master_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [0:ADR_W-1] m0_adr_i,
   input  logic [0:DAT_W-1] m0_dat_i,
   output logic [0:DAT_W-1] m0_dat_o,
   input  logic             m0_we_i,
   input  logic [0:SEL_W-1] m0_sel_i,
   input  logic             m0_stb_i,
   input  logic             m0_cyc_i,
   output logic             m0_ack_o,
   output logic             m0_err_o,
   input  logic [0:ADR_W-1] m1_adr_i,
   input  logic [0:DAT_W-1] m1_dat_i,
   output logic [0:DAT_W-1] m1_dat_o,
   input  logic             m1_we_i,
   input  logic [0:SEL_W-1] m1_sel_i,
   input  logic             m1_stb_i,
   input  logic             m1_cyc_i,
   output logic             m1_ack_o,
   output logic             m1_err_o,
   output logic [0:ADR_W-1] s_adr_o,
   output logic [0:DAT_W-1] s_dat_o,
   output logic             s_we_o,
   output logic [0:SEL_W-1] s_sel_o,
   output logic             s_stb_o,
   output logic             s_cyc_o,
   input  logic [0:DAT_W-1] s_dat_i,
   input  logic             s_ack_i,
   output logic [0:GNT_W-1] grant_o
);

   owner_e  state_q, state_d;
   logic    last_q, last_d;   // 1: m1 was served last, so m0 wins a tie
   wb_req_t req0, req1, bus_c;
   logic    timeout_c;

   assign req0 = '{cyc: m0_cyc_i, stb: m0_stb_i, we: m0_we_i,
                   sel: m0_sel_i, adr: m0_adr_i, dat: m0_dat_i};
   assign req1 = '{cyc: m1_cyc_i, stb: m1_stb_i, we: m1_we_i,
                   sel: m1_sel_i, adr: m1_adr_i, dat: m1_dat_i};

   // Owner and last-served registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= OWN_IDLE;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   // Arbitration: grant from IDLE only, release on owner's cyc drop.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      unique case (state_q)
         OWN_IDLE: begin
            if (m0_cyc_i && m1_cyc_i) begin
               state_d = last_q ? OWN_M0 : OWN_M1;
            end else if (m0_cyc_i) begin
               state_d = OWN_M0;
            end else if (m1_cyc_i) begin
               state_d = OWN_M1;
            end
         end
         OWN_M0: begin
            if (!m0_cyc_i) begin
               state_d = OWN_IDLE;
               last_d  = 1'b0;
            end
         end
         OWN_M1: begin
            if (!m1_cyc_i) begin
               state_d = OWN_IDLE;
               last_d  = 1'b1;
            end
         end
         default: state_d = OWN_IDLE;
      endcase
   end

   // Owner mux; a strobe without the owner's live cyc is an abandoned transfer.
   always_comb begin
      bus_c = '0;
      unique case (state_q)
         OWN_M0:  bus_c = req0;
         OWN_M1:  bus_c = req1;
         default: bus_c = '0;
      endcase
      bus_c.stb = bus_c.stb & bus_c.cyc;
   end

   wb_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk       (clk),
      .reset     (reset),
      .stb       (bus_c.stb),
      .ack       (s_ack_i),
      .timeout_c (timeout_c)
   );

   assign s_cyc_o = bus_c.cyc;
   assign s_stb_o = bus_c.stb & ~timeout_c;
   assign s_we_o  = bus_c.we;
   assign s_sel_o = bus_c.sel;
   assign s_adr_o = bus_c.adr;
   assign s_dat_o = bus_c.dat;
   assign grant_o = owner_grant(state_q);

   // Responses reach the owner only; nothing is delivered while in reset.
   assign m0_ack_o = (state_q == OWN_M0) && s_ack_i && !reset;
   assign m1_ack_o = (state_q == OWN_M1) && s_ack_i && !reset;
   assign m0_err_o = (state_q == OWN_M0) && timeout_c && !reset;
   assign m1_err_o = (state_q == OWN_M1) && timeout_c && !reset;
   assign m0_dat_o = (state_q == OWN_M0) ? s_dat_i : '0;
   assign m1_dat_o = (state_q == OWN_M1) ? s_dat_i : '0;

endmodule
